// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU opcodes and the multiply sequencer state encoding.
package mips_pkg;

    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_SLT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        ITER,
        NEG_LO,
        NEG_HI,
        NEG_DEC,
        DONE
    } mult_state_t;

    function automatic logic is_busy_state(input mult_state_t s);
        return (s == ITER) || (s == NEG_LO) || (s == NEG_HI) || (s == NEG_DEC);
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Ripple ALU built from 1-bit slices; op[2] inverts B and feeds the LSB carry-in.
module mips_alu
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_c_o,
    output logic             cout_c_o
);

    logic             binv;
    logic             carry;
    logic             bb;
    logic [WIDTH-1:0] sum;

    assign binv = op_i[2];

    // Slice chain: each bit adds a, (b ^ binv) and the carry from the bit below.
    always_comb begin
        carry = binv;
        bb    = 1'b0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bb     = b_i[i] ^ binv;
            sum[i] = a_i[i] ^ bb ^ carry;
            carry  = (a_i[i] & bb) | (a_i[i] & carry) | (bb & carry);
        end
        cout_c_o = carry;
    end

    always_comb begin
        result_c_o = '0;
        case (op_i)
            ALUOP_AND: result_c_o = a_i & b_i;
            ALUOP_OR:  result_c_o = a_i | b_i;
            ALUOP_ADD: result_c_o = sum;
            ALUOP_SUB: result_c_o = sum;
            ALUOP_SLT: result_c_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
            default:   result_c_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_mult_seq.sv
// Shift-add multiply sequencer driving the shared datapath ALU; product lands in hi/lo.
// Signed MULT support is enabled with `define MIPS_MULT_SIGNED_EN.
module mips_mult_seq
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             signed_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mult_state_t      state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             neg_q, neg_d;
    logic             lz_q, lz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;

`ifndef MIPS_MULT_SIGNED_EN
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ITER;
            ITER:    if (count_q == LAST_ITER) state_d = neg_q ? NEG_LO : DONE;
            NEG_LO:  state_d = NEG_HI;
            NEG_HI:  state_d = NEG_DEC;
            NEG_DEC: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values, then the registered ALU drive for the state being entered.
    always_comb begin
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        count_d = count_q;
        neg_d   = neg_q;
        lz_d    = lz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a_in;
                    hi_d    = '0;
                    lo_d    = b_in;
                    count_d = '0;
                    neg_d   = 1'b0;
`ifdef MIPS_MULT_SIGNED_EN
                    if (signed_op) begin
                        neg_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        if (a_in[WIDTH-1]) mcand_d = -a_in;
                        if (b_in[WIDTH-1]) lo_d    = -b_in;
                    end
`endif
                end
            end
            ITER: begin
                hi_d    = {alu_cout, alu_result[WIDTH-1:1]};
                lo_d    = {alu_result[0], lo_q[WIDTH-1:1]};
                count_d = count_q + CNT_W'(1);
            end
            NEG_LO: begin
                lo_d = alu_result;
                lz_d = (lo_q == '0);
            end
            NEG_HI:  hi_d = alu_result;
            NEG_DEC: hi_d = alu_result;
            default: ;
        endcase

        busy_d   = is_busy_state(state_d);
        done_d   = (state_d == DONE);
        alu_a_d  = '0;
        alu_b_d  = '0;
        alu_op_d = ALUOP_AND;
        case (state_d)
            ITER: begin
                alu_a_d  = hi_d;
                alu_b_d  = lo_d[0] ? mcand_d : '0;
                alu_op_d = ALUOP_ADD;
            end
            NEG_LO: begin
                alu_b_d  = lo_d;
                alu_op_d = ALUOP_SUB;
            end
            NEG_HI: begin
                alu_b_d  = hi_d;
                alu_op_d = ALUOP_SUB;
            end
            NEG_DEC: begin
                // Borrow from the low half unless it negated to zero.
                alu_a_d  = hi_d;
                alu_b_d  = {{(WIDTH-1){1'b0}}, ~lz_d};
                alu_op_d = ALUOP_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            lz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= ALUOP_AND;
        end else begin
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            lz_q     <= lz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

endmodule

// File: tb/tb_mips_mult_seq.sv
// Self-checking bench for mips_mult_seq wired to the real slice ALU.
module tb_mips_mult_seq;

`ifdef MIPS_MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        signed_op;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_cout;

    int n_tests = 0;
    int n_fail  = 0;

    mips_mult_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .signed_op(signed_op), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    mips_alu #(.WIDTH(32)) u_alu (
        .a_i(alu_a), .b_i(alu_b), .op_i(alu_op),
        .result_c_o(alu_result), .cout_c_o(alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Mathematical product of the two operands as the requested kind of multiply.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint sa, sb;
        longint unsigned ua, ub;
        if (s && SIGNED_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return 64'(ua * ub);
    endfunction

    // Cycle of the done pulse, counting the start-sampling cycle as 0.
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s && SIGNED_EN && (a[31] ^ b[31])) return 36;
        return 33;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a start in the current cycle; returns in cycle 1.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        a_in      = a;
        b_in      = b;
        signed_op = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Called in cycle 1; returns the cycle index of done, or -1 if it never came.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc <= 100) begin
            tick();
            cyc++;
        end
        if (cyc > 100) cyc = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) tick();
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (hi !== 32'h0)       begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_tests++; if (lo !== 32'h0)       begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_tests++; if (alu_a !== 32'h0)    begin n_fail++; $display("FAIL reset_alu_a: got %h want 0", alu_a); end
        n_tests++; if (alu_b !== 32'h0)    begin n_fail++; $display("FAIL reset_alu_b: got %h want 0", alu_b); end
        n_tests++; if (alu_op !== 3'b000)  begin n_fail++; $display("FAIL reset_alu_op: got %b want 000", alu_op); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_unsigned_basic;
        int done_cyc;
        done_cyc = -1;
        start_op(32'd3, 32'd5, 1'b0);
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                n_tests++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy cycle %0d: got %b want 1", cyc, busy); end
                tick();
            end
        end
        n_tests++; if (done_cyc != 33)  begin n_fail++; $display("FAIL basic_latency: got %0d want 33", done_cyc); end
        n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        n_tests++; if (hi !== 32'd0)    begin n_fail++; $display("FAIL basic_hi: got %h want 0", hi); end
        n_tests++; if (lo !== 32'd15)   begin n_fail++; $display("FAIL basic_lo: got %h want f", lo); end
        tick();
    endtask

    task automatic test_unsigned_max;
        int busy_cycles;
        int done_cyc;
        busy_cycles = 0;
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        done_cyc = 1;
        while (done !== 1'b1 && done_cyc <= 100) begin
            busy_cycles++;
            n_tests++;
            if (alu_op !== 3'b010) begin n_fail++; $display("FAIL max_alu_op cycle %0d: got %b want 010", done_cyc, alu_op); end
            tick();
            done_cyc++;
        end
        n_tests++; if (done_cyc != 33)       begin n_fail++; $display("FAIL max_latency: got %0d want 33", done_cyc); end
        n_tests++; if (busy_cycles != 32)    begin n_fail++; $display("FAIL max_iter_count: got %0d want 32", busy_cycles); end
        n_tests++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL max_hi: got %h want fffffffe", hi); end
        n_tests++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL max_lo: got %h want 00000001", lo); end
        tick();
    endtask

    task automatic test_handshake;
        int done_cyc;
        int cyc2;
        done_cyc = -1;
        start_op(32'd3, 32'd5, 1'b0);
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                start = (cyc == 5);
                if (cyc == 5) begin a_in = 32'd7; b_in = 32'd7; end
                tick();
            end
        end
        n_tests++; if (done_cyc != 33)  begin n_fail++; $display("FAIL hs_first_latency: got %0d want 33", done_cyc); end
        n_tests++; if (lo !== 32'd15)   begin n_fail++; $display("FAIL hs_first_lo: got %h want f", lo); end
        // Start during DONE is ignored; held start in the following IDLE cycle is taken.
        a_in  = 32'd7;
        b_in  = 32'd7;
        start = 1'b1;
        tick();
        n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL hs_done_start_ignored: busy got %b want 0", busy); end
        n_tests++; if (lo !== 32'd15)   begin n_fail++; $display("FAIL hs_hold_lo: got %h want f", lo); end
        tick();
        start = 1'b0;
        wait_done(cyc2);
        n_tests++; if (cyc2 != 33)      begin n_fail++; $display("FAIL hs_second_latency: got %0d want 33 (cycle 67)", cyc2); end
        n_tests++; if (lo !== 32'd49)   begin n_fail++; $display("FAIL hs_second_lo: got %h want 31", lo); end
        n_tests++; if (hi !== 32'd0)    begin n_fail++; $display("FAIL hs_second_hi: got %h want 0", hi); end
        tick();
    endtask

    task automatic test_reset_mid;
        bit seen_done;
        start_op(32'hDEAD_BEEF, 32'h1234_5679, 1'b0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL rmid_done: got %b want 0", done); end
        n_tests++; if (hi !== 32'h0)      begin n_fail++; $display("FAIL rmid_hi: got %h want 0", hi); end
        n_tests++; if (lo !== 32'h0)      begin n_fail++; $display("FAIL rmid_lo: got %h want 0", lo); end
        n_tests++; if (alu_op !== 3'b000) begin n_fail++; $display("FAIL rmid_alu_op: got %b want 000", alu_op); end
        seen_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
            tick();
        end
        n_tests++; if (seen_done)         begin n_fail++; $display("FAIL rmid_no_activity: got activity want none"); end
    endtask

    task automatic test_zero;
        int done_cyc;
        start_op(32'h1234_5678, 32'h0, 1'b0);
        done_cyc = 1;
        while (done !== 1'b1 && done_cyc <= 100) begin
            n_tests++;
            if (alu_b !== 32'h0) begin n_fail++; $display("FAIL zero_alu_b cycle %0d: got %h want 0", done_cyc, alu_b); end
            tick();
            done_cyc++;
        end
        n_tests++; if (done_cyc != 33) begin n_fail++; $display("FAIL zero_latency: got %0d want 33", done_cyc); end
        n_tests++; if (hi !== 32'h0)   begin n_fail++; $display("FAIL zero_hi: got %h want 0", hi); end
        n_tests++; if (lo !== 32'h0)   begin n_fail++; $display("FAIL zero_lo: got %h want 0", lo); end
        tick();
    endtask

    task automatic test_signed;
        int cyc;
        logic [31:0] exp_hi, exp_lo;
        int exp_cyc;
`ifdef MIPS_MULT_SIGNED_EN
        exp_cyc = 36; exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF1;
`else
        exp_cyc = 33; exp_hi = 32'h0000_0004; exp_lo = 32'hFFFF_FFF1;
`endif
        start_op(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done(cyc);
        n_tests++; if (cyc != exp_cyc) begin n_fail++; $display("FAIL sgn_m3x5_latency: got %0d want %0d", cyc, exp_cyc); end
        n_tests++; if (hi !== exp_hi)  begin n_fail++; $display("FAIL sgn_m3x5_hi: got %h want %h", hi, exp_hi); end
        n_tests++; if (lo !== exp_lo)  begin n_fail++; $display("FAIL sgn_m3x5_lo: got %h want %h", lo, exp_lo); end
        tick();
`ifdef MIPS_MULT_SIGNED_EN
        exp_hi = 32'h0; exp_lo = 32'd16;
`else
        exp_hi = 32'hFFFF_FFF8; exp_lo = 32'd16;
`endif
        start_op(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
        wait_done(cyc);
        n_tests++; if (cyc != 33)      begin n_fail++; $display("FAIL sgn_m4xm4_latency: got %0d want 33", cyc); end
        n_tests++; if (hi !== exp_hi)  begin n_fail++; $display("FAIL sgn_m4xm4_hi: got %h want %h", hi, exp_hi); end
        n_tests++; if (lo !== exp_lo)  begin n_fail++; $display("FAIL sgn_m4xm4_lo: got %h want %h", lo, exp_lo); end
        tick();
    endtask

    // Back-to-back random multiplies issued at the minimum interval.
    task automatic test_back_to_back_random;
        logic [31:0] a, b;
        logic        s;
        logic [63:0] exp_p, prev_p;
        int          cyc, exp_cyc;
        prev_p = 64'h0;
        for (int n = 0; n < 24; n++) begin
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: b = 32'h8000_0000;
                2: b = 32'h0;
                3: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            s = 1'(($urandom_range(0, 1)));
            if (n > 0) begin
                n_tests++;
                if ({hi, lo} !== prev_p) begin n_fail++; $display("FAIL b2b_hold #%0d: got %h want %h", n, {hi, lo}, prev_p); end
            end
            exp_p   = ref_prod(a, b, s);
            exp_cyc = ref_lat(a, b, s);
            start_op(a, b, s);
            wait_done(cyc);
            n_tests++;
            if (cyc != exp_cyc) begin n_fail++; $display("FAIL b2b_latency #%0d a=%h b=%h s=%b: got %0d want %0d", n, a, b, s, cyc, exp_cyc); end
            n_tests++;
            if ({hi, lo} !== exp_p) begin n_fail++; $display("FAIL b2b_product #%0d a=%h b=%h s=%b: got %h want %h", n, a, b, s, {hi, lo}, exp_p); end
            prev_p = exp_p;
            tick();
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        a_in      = 32'h0;
        b_in      = 32'h0;
        signed_op = 1'b0;
        test_reset();
        test_unsigned_basic();
        test_unsigned_max();
        test_handshake();
        test_reset_mid();
        test_zero();
        test_signed();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
